// File: rtl/decodificador_servo_pkg.sv
// Shared constants, state codes and threshold helper for the servo PWM decoder.
package servo_pkg;

    localparam int LARGURA_0_PADRAO   = 36_111;
    localparam int PASSO_PADRAO       = 11_111;
    localparam int TOLERANCIA_PADRAO  = 2_000;
    localparam int PERIODO_MAX_PADRAO = 1_250_000;

    localparam logic [3:0] EST_ESPERA_BAIXO  = 4'd0;
    localparam logic [3:0] EST_ESPERA_SUBIDA = 4'd1;
    localparam logic [3:0] EST_MEDE          = 4'd2;
    localparam logic [3:0] EST_AVALIA        = 4'd3;

    typedef enum logic [3:0] {
        ESPERA_BAIXO  = EST_ESPERA_BAIXO,
        ESPERA_SUBIDA = EST_ESPERA_SUBIDA,
        MEDE          = EST_MEDE,
        AVALIA        = EST_AVALIA
    } estado_t;

    // Lower width bound for position k: halfway between nominal widths k-1 and k.
    // Called only with constant arguments, so it folds to a constant compare.
    function automatic logic [20:0] limiar(input int largura_0, input int passo, input int k);
        return 21'(largura_0 + k * passo - passo / 2);
    endfunction

endpackage

// File: rtl/decodificador_servo_sincroniza_borda.sv
// Two-flop synchronizer for the asynchronous PWM input plus an edge register.
// The flops are deliberately not reset so that a pulse already high during
// reset never looks like a fresh rising edge once reset is released.
module sincroniza_borda (
    input  logic clock,
    input  logic entrada,
    output logic nivel,
    output logic subida,
    output logic descida
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronize the input and keep the previous synchronized level.
    always_ff @(posedge clock) begin
        s1_q <= entrada;
        s2_q <= s1_q;
        s3_q <= s2_q;
    end

    assign nivel   = s2_q;
    assign subida  = s2_q & ~s3_q;
    assign descida = ~s2_q & s3_q;

endmodule

// File: rtl/decodificador_servo.sv
// Servo PWM receiver: measures each high pulse, decodes it to a 3-bit
// position, flags out-of-range pulses and loss of signal.
//
// state         | meaning
// ESPERA_BAIXO  | wait for a low input so a pulse in flight is discarded
// ESPERA_SUBIDA | idle, waiting for the next rising edge
// MEDE          | counting high cycles of the current pulse
// AVALIA        | pulse ended, hand the count to the result stage
module decodificador_servo
    import servo_pkg::*;
#(
    parameter int LARGURA_0   = LARGURA_0_PADRAO,
    parameter int PASSO       = PASSO_PADRAO,
    parameter int TOLERANCIA  = TOLERANCIA_PADRAO,
    parameter int PERIODO_MAX = PERIODO_MAX_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [2:0]  posicao,
    output logic [20:0] largura,
    output logic        pronto,
    output logic        erro,
    output logic        sem_sinal,
    output logic [3:0]  db_estado
);

    localparam logic [20:0] LARG_MIN = 21'(LARGURA_0 - TOLERANCIA);
    localparam logic [20:0] LARG_MAX = 21'(LARGURA_0 + 7 * PASSO + TOLERANCIA);
    localparam logic [20:0] PER_MAX  = 21'(PERIODO_MAX);

    logic nivel;
    logic subida;
    logic descida;

    estado_t     estado_q, estado_d;
    logic [20:0] cont_q, cont_d;
    logic [20:0] medida_q, medida_d;
    logic        fim_q, fim_d;
    logic [20:0] largura_q, largura_d;
    logic [2:0]  posicao_q, posicao_d;
    logic        erro_q, erro_d;
    logic        pronto_q, pronto_d;
    logic [20:0] periodo_q, periodo_d;
    logic        sem_sinal_q, sem_sinal_d;
    logic        valida;
    logic [2:0]  pos_dec;

    sincroniza_borda u_sincroniza (
        .clock   (clock),
        .entrada (pwm_in),
        .nivel   (nivel),
        .subida  (subida),
        .descida (descida)
    );

    // Measurement FSM: count the pulse and hand the final count to the result stage.
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        medida_d = medida_q;
        fim_d    = 1'b0;
        case (estado_q)
            ESPERA_BAIXO: begin
                if (!nivel) estado_d = ESPERA_SUBIDA;
            end
            ESPERA_SUBIDA: begin
                if (subida) begin
                    cont_d   = 21'd1;
                    estado_d = MEDE;
                end
            end
            MEDE: begin
                if (descida) begin
                    estado_d = AVALIA;
                end else if (cont_q > LARG_MAX) begin
                    // Stuck-high or overlong pulse: report it now and resync on the next low.
                    medida_d = cont_q;
                    fim_d    = 1'b1;
                    estado_d = ESPERA_BAIXO;
                end else if (nivel) begin
                    cont_d = cont_q + 21'd1;
                end
            end
            AVALIA: begin
                medida_d = cont_q;
                fim_d    = 1'b1;
                estado_d = ESPERA_SUBIDA;
            end
            default: estado_d = ESPERA_BAIXO;
        endcase
    end

    // Result stage: range check and decode of the finished measurement.
    always_comb begin
        valida  = (medida_q >= LARG_MIN) && (medida_q <= LARG_MAX);
        pos_dec = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (medida_q >= limiar(LARGURA_0, PASSO, k)) pos_dec = 3'(k);
        end
        largura_d = largura_q;
        posicao_d = posicao_q;
        erro_d    = erro_q;
        pronto_d  = fim_q;
        if (fim_q) begin
            largura_d = medida_q;
            if (valida) begin
                posicao_d = pos_dec;
                erro_d    = 1'b0;
            end else begin
                erro_d = 1'b1;
            end
        end
    end

    // Loss-of-signal watchdog: cycles since the last rising edge, saturating.
    always_comb begin
        if (subida)                  periodo_d = '0;
        else if (periodo_q == PER_MAX) periodo_d = PER_MAX;
        else                         periodo_d = periodo_q + 21'd1;
        sem_sinal_d = (periodo_d == PER_MAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= ESPERA_BAIXO;
            cont_q      <= '0;
            medida_q    <= '0;
            fim_q       <= 1'b0;
            largura_q   <= '0;
            posicao_q   <= 3'd0;
            erro_q      <= 1'b0;
            pronto_q    <= 1'b0;
            periodo_q   <= '0;
            sem_sinal_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            medida_q    <= medida_d;
            fim_q       <= fim_d;
            largura_q   <= largura_d;
            posicao_q   <= posicao_d;
            erro_q      <= erro_d;
            pronto_q    <= pronto_d;
            periodo_q   <= periodo_d;
            sem_sinal_q <= sem_sinal_d;
        end
    end

    assign posicao   = posicao_q;
    assign largura   = largura_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign sem_sinal = sem_sinal_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_decodificador_servo.sv
// Bench for decodificador_servo with scaled-down timing parameters.
module tb_decodificador_servo;

    localparam int L0   = 361;
    localparam int P    = 111;
    localparam int TOL  = 20;
    localparam int PM   = 5000;
    localparam int MINW = L0 - TOL;
    localparam int MAXW = L0 + 7 * P + TOL;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [2:0]  posicao;
    logic [20:0] largura;
    logic        pronto;
    logic        erro;
    logic        sem_sinal;
    logic [3:0]  db_estado;

    decodificador_servo #(
        .LARGURA_0   (L0),
        .PASSO       (P),
        .TOLERANCIA  (TOL),
        .PERIODO_MAX (PM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .posicao   (posicao),
        .largura   (largura),
        .pronto    (pronto),
        .erro      (erro),
        .sem_sinal (sem_sinal),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int due;
        int larg;
        bit valid;
        int pos;
    } exp_t;

    exp_t fila[$];
    int   m_pos = 0;
    int   m_erro = 0;
    int   m_larg = 0;
    int   base = 0;
    int   prox_base = -1;
    bit   chk_en = 1'b0;

    task automatic chk(input string nome, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nome, cyc, got, exp_v);
        end
    endtask

    // What the decoder must report for a pulse of n high cycles whose first
    // high sample is at clock edge h0.
    function automatic exp_t modelo(input int n, input int h0);
        exp_t e;
        if (n >= MAXW + 2) begin
            e.larg = MAXW + 1;
            e.due  = h0 + MAXW + 4;
        end else begin
            e.larg = n;
            e.due  = h0 + n + 4;
        end
        e.valid = (e.larg >= MINW) && (e.larg <= MAXW);
        e.pos = 0;
        for (int k = 1; k < 8; k++)
            if (e.larg >= L0 + k * P - P / 2) e.pos = k;
        return e;
    endfunction

    // Per-cycle comparison against the model.
    int exp_pronto;
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            exp_pronto = 0;
            if (prox_base >= 0 && cyc >= prox_base) begin
                base = prox_base;
                prox_base = -1;
            end
            if (fila.size() > 0 && fila[0].due == cyc) begin
                exp_pronto = 1;
                m_larg = fila[0].larg;
                if (fila[0].valid) begin
                    m_pos  = fila[0].pos;
                    m_erro = 0;
                end else begin
                    m_erro = 1;
                end
                void'(fila.pop_front());
            end
            chk("pronto", int'(pronto), exp_pronto);
            chk("largura", int'(largura), m_larg);
            chk("posicao", int'(posicao), m_pos);
            chk("erro", int'(erro), m_erro);
            chk("sem_sinal", int'(sem_sinal), (cyc - base >= PM) ? 1 : 0);
            chk("db_estado_range", (db_estado <= 4'd3) ? 1 : 0, 1);
        end
    end

    task automatic espera(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic aplica_reset(input int n);
        reset = 1'b1;
        fila.delete();
        m_pos = 0;
        m_erro = 0;
        m_larg = 0;
        prox_base = -1;
        espera(n);
        reset = 1'b0;
        base = cyc;
    endtask

    task automatic pulso(input int n, input int gap);
        int h0;
        h0 = cyc + 1;
        fila.push_back(modelo(n, h0));
        prox_base = h0 + 2;
        pwm_in = 1'b1;
        espera(n);
        pwm_in = 1'b0;
        espera(gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        pwm_in = 1'b0;
        espera(2);
        aplica_reset(5);
        chk_en = 1'b1;
        espera(100);
        chk("idle_db_estado", int'(db_estado), 1);
        chk("idle_posicao", int'(posicao), 0);
        chk("idle_largura", int'(largura), 0);
        chk("idle_sem_sinal", int'(sem_sinal), 0);

        pulso(361, 300);
        chk("w361_posicao", int'(posicao), 0);
        chk("w361_largura", int'(largura), 361);
        chk("w361_erro", int'(erro), 0);
        pulso(416, 300);
        chk("w416_posicao", int'(posicao), 0);
        pulso(417, 300);
        chk("w417_posicao", int'(posicao), 1);
        pulso(1139, 300);
        chk("w1139_posicao", int'(posicao), 7);
        pulso(417, 300);
        pulso(200, 300);
        chk("w200_erro", int'(erro), 1);
        chk("w200_posicao", int'(posicao), 1);
        chk("w200_largura", int'(largura), 200);
        pulso(750, 300);
        chk("w750_posicao", int'(posicao), 4);
        chk("w750_erro", int'(erro), 0);
        pulso(341, 300);
        chk("w341_erro", int'(erro), 0);
        pulso(340, 300);
        chk("w340_erro", int'(erro), 1);
        pulso(1158, 300);
        chk("w1158_posicao", int'(posicao), 7);
        chk("w1158_erro", int'(erro), 0);
        pulso(1159, 300);
        chk("w1159_erro", int'(erro), 1);
        pulso(2000, 300);
        chk("stuck_erro", int'(erro), 1);
        chk("stuck_largura", int'(largura), 1159);
        chk("stuck_posicao", int'(posicao), 7);

        espera(6000);
        chk("loss_sem_sinal", int'(sem_sinal), 1);
        pulso(361, 300);
        chk("loss_clear_sem_sinal", int'(sem_sinal), 0);
        chk("loss_clear_posicao", int'(posicao), 0);

        prox_base = cyc + 3;
        pwm_in = 1'b1;
        espera(200);
        chk("mid_db_estado", int'(db_estado), 2);
        aplica_reset(3);
        espera(5);
        chk("after_reset_db_estado", int'(db_estado), 0);
        espera(431);
        pwm_in = 1'b0;
        espera(300);
        pulso(583, 300);
        chk("w583_posicao", int'(posicao), 2);
        chk("w583_largura", int'(largura), 583);

        chk("pending_expectations", fila.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
